btb_redirect_unit: RTL and testbench

BTB_REDIRECT_UNIT -- requirements
Module: btb_redirect_unit

---
 rtl/btb_redirect_unit.sv | 151 +++++++++++++++
 tb/tb_btb_redirect_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_redirect_unit.sv
// rtl/btb_redirect_unit.sv - branch target buffer with fetch prediction and EX-stage redirect
//
// Direct-mapped BTB consulted at fetch to pick next_pc, a two-deep prediction
// pipeline (IF->ID->EX) carrying what fetch assumed, and EX-stage resolution
// that raises mispredict/redirect_pc and trains the BTB on taken control flow.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   stall                pipeline hold, freezes all state
//   if_pc, if_opcode     fetch address and opcode of the fetched instruction
//   pred_br              direction predictor opinion for if_pc
//   ex_valid, ex_pc      EX instruction presence and address
//   ex_is_br, ex_is_jump EX instruction class (conditional branch / JAL-JALR)
//   ex_br_en, ex_target  resolved branch condition and target
//   next_pc              PC to fetch next cycle
//   if_pred_taken        fetch predicted taken
//   mispredict           EX resolution disagrees with the carried prediction
//   redirect_pc          correct next PC (meaningful while mispredict is high)
//   pred_ld, write_pc    direction predictor update strobe and its PC
//   mispredict_count     saturating count of mispredicts

module btb_redirect_unit #(
    parameter int idx_width = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] if_pc,
    input  logic [6:0]  if_opcode,
    input  logic        pred_br,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_br,
    input  logic        ex_is_jump,
    input  logic        ex_br_en,
    input  logic [31:0] ex_target,
    output logic [31:0] next_pc,
    output logic        if_pred_taken,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        pred_ld,
    output logic [31:0] write_pc,
    output logic [15:0] mispredict_count
);

    localparam int entries   = 1 << idx_width;
    localparam int tag_width = 30 - idx_width;

    localparam logic [6:0] op_jal    = 7'b1101111;
    localparam logic [6:0] op_branch = 7'b1100011;

    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_t;

    // BTB storage; only the valid bits need reset
    logic [entries-1:0]   btb_valid;
    logic [tag_width-1:0] btb_tag    [entries];
    logic [31:0]          btb_target [entries];

    logic [idx_width-1:0] if_idx;
    logic [tag_width-1:0] if_tag;
    logic [idx_width-1:0] ex_idx;
    logic [tag_width-1:0] ex_tag;

    logic        hit;
    logic        is_jal;
    logic        is_branch;
    logic        ex_taken;
    logic        btb_we;
    logic [31:0] ex_seq_pc;

    pred_t stage1;
    pred_t stage2;

    assign if_idx = if_pc[idx_width+1:2];
    assign if_tag = if_pc[31:idx_width+2];
    assign ex_idx = ex_pc[idx_width+1:2];
    assign ex_tag = ex_pc[31:idx_width+2];

    // Fetch-side lookup. A write in the same cycle is not bypassed: the read
    // sees the entry as it stood before the edge.
    assign hit       = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign is_jal    = (if_opcode == op_jal);
    assign is_branch = (if_opcode == op_branch);

    assign if_pred_taken = hit && (is_jal || (is_branch && pred_br));
    assign next_pc       = if_pred_taken ? btb_target[if_idx] : (if_pc + 32'd4);

    // EX-side resolution
    assign ex_taken    = ex_is_jump || (ex_is_br && ex_br_en);
    assign ex_seq_pc   = ex_pc + 32'd4;
    assign redirect_pc = ex_taken ? ex_target : ex_seq_pc;

    // Target is only compared when both sides agree on taken; a not-taken
    // prediction carries a sequential address that must not matter.
    assign mispredict = ex_valid && !stall && stage2.valid &&
                        ((ex_taken != stage2.pred_taken) ||
                         (ex_taken && (ex_target != stage2.pred_target)));

    assign pred_ld  = ex_valid && ex_is_br && !stall;
    assign write_pc = ex_pc;

    // Only taken control flow trains the BTB; not-taken leaves entries alone
    assign btb_we = ex_valid && !stall && ex_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (btb_we) begin
            btb_valid[ex_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target;
        end
    end

    // Prediction pipeline. Every fetched slot is marked valid so that a
    // resolution with no BTB prediction is still checked (as predicted
    // not-taken). A mispredict squashes both younger slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1 <= '0;
            stage2 <= '0;
        end else if (!stall) begin
            if (mispredict) begin
                stage1 <= '0;
                stage2 <= '0;
            end else begin
                stage1 <= '{valid: 1'b1, pred_taken: if_pred_taken, pred_target: next_pc};
                stage2 <= stage1;
            end
        end
    end

    // mispredict is already gated by stall, so the counter holds during stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_count <= '0;
        end else if (mispredict && (mispredict_count != 16'hFFFF)) begin
            mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_btb_redirect_unit.sv
// tb/tb_btb_redirect_unit.sv - directed scoreboard bench for btb_redirect_unit

module tb_btb_redirect_unit;

    localparam logic [6:0] op_jal = 7'h6F;
    localparam logic [6:0] op_br  = 7'h63;
    localparam logic [6:0] op_alu = 7'h13;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        pred_br;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_br;
    logic        ex_is_jump;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic [31:0] next_pc;
    logic        if_pred_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        pred_ld;
    logic [31:0] write_pc;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    btb_redirect_unit #(.idx_width(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .if_pc            (if_pc),
        .if_opcode        (if_opcode),
        .pred_br          (pred_br),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_br         (ex_is_br),
        .ex_is_jump       (ex_is_jump),
        .ex_br_en         (ex_br_en),
        .ex_target        (ex_target),
        .next_pc          (next_pc),
        .if_pred_taken    (if_pred_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .pred_ld          (pred_ld),
        .write_pc         (write_pc),
        .mispredict_count (mispredict_count)
    );

    typedef enum int {S_NEXT, S_PT, S_MP, S_RED, S_LD, S_WPC, S_CNT} sel_t;

    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            S_NEXT:  return next_pc;
            S_PT:    return {31'd0, if_pred_taken};
            S_MP:    return {31'd0, mispredict};
            S_RED:   return redirect_pc;
            S_LD:    return {31'd0, pred_ld};
            S_WPC:   return write_pc;
            S_CNT:   return {16'd0, mispredict_count};
            default: return 'x;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t s, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t        x;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = observe(x.sel);
            checks++;
            assert (o === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [6:0] op, input logic pb);
        if_pc     = pc;
        if_opcode = op;
        pred_br   = pb;
    endtask

    task automatic ex_idle();
        ex_valid   = 1'b0;
        ex_pc      = 32'd0;
        ex_is_br   = 1'b0;
        ex_is_jump = 1'b0;
        ex_br_en   = 1'b0;
        ex_target  = 32'd0;
    endtask

    task automatic ex_set(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic en, input logic [31:0] tgt);
        ex_valid   = 1'b1;
        ex_pc      = pc;
        ex_is_br   = br;
        ex_is_jump = jmp;
        ex_br_en   = en;
        ex_target  = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        fetch(32'h100, op_jal, 1'b0);
        ex_idle();
        #2;
        expect_val("rst_pt",   S_PT,   32'd0);
        expect_val("rst_next", S_NEXT, 32'h104);
        expect_val("rst_mp",   S_MP,   32'd0);
        expect_val("rst_ld",   S_LD,   32'd0);
        expect_val("rst_cnt",  S_CNT,  32'd0);
        check_all();
        tick();
        rst = 1'b1;

        // c0: cold fetch of JAL at 0x100 misses
        expect_val("c0_pt",   S_PT,   32'd0);
        expect_val("c0_next", S_NEXT, 32'h104);
        expect_val("c0_mp",   S_MP,   32'd0);
        expect_val("c0_ld",   S_LD,   32'd0);
        expect_val("c0_cnt",  S_CNT,  32'd0);
        check_all();
        tick();

        // c1
        fetch(32'h104, op_alu, 1'b0);
        tick();

        // c2: JAL 0x100->0x200 resolves against a not-taken prediction
        fetch(32'h108, op_alu, 1'b0);
        ex_set(32'h100, 1'b0, 1'b1, 1'b0, 32'h200);
        expect_val("c2_mp",  S_MP,  32'd1);
        expect_val("c2_red", S_RED, 32'h200);
        expect_val("c2_ld",  S_LD,  32'd0);
        check_all();
        tick();

        // c3: BTB now holds 0x100->0x200; opcode gating
        ex_idle();
        fetch(32'h100, op_alu, 1'b0);
        expect_val("c3_cnt",     S_CNT,  32'd1);
        expect_val("c3_alu_pt",  S_PT,   32'd0);
        expect_val("c3_alu_nx",  S_NEXT, 32'h104);
        check_all();
        fetch(32'h100, op_br, 1'b0);
        expect_val("c3_brnt_pt", S_PT,   32'd0);
        expect_val("c3_brnt_nx", S_NEXT, 32'h104);
        check_all();
        fetch(32'h100, op_br, 1'b1);
        expect_val("c3_brt_pt",  S_PT,   32'd1);
        expect_val("c3_brt_nx",  S_NEXT, 32'h200);
        check_all();
        fetch(32'h100, op_jal, 1'b0);
        expect_val("c3_jal_pt",  S_PT,   32'd1);
        expect_val("c3_jal_nx",  S_NEXT, 32'h200);
        check_all();
        tick();

        // c4
        fetch(32'h200, op_alu, 1'b0);
        tick();

        // c5: correct prediction
        fetch(32'h204, op_alu, 1'b0);
        ex_set(32'h100, 1'b0, 1'b1, 1'b0, 32'h200);
        expect_val("c5_mp",  S_MP,  32'd0);
        expect_val("c5_red", S_RED, 32'h200);
        check_all();
        tick();

        // c6: branch 0x140 taken to 0x180 against not-taken slot
        fetch(32'h208, op_alu, 1'b0);
        ex_set(32'h140, 1'b1, 1'b0, 1'b1, 32'h180);
        expect_val("c6_cnt", S_CNT, 32'd1);
        expect_val("c6_mp",  S_MP,  32'd1);
        expect_val("c6_red", S_RED, 32'h180);
        expect_val("c6_ld",  S_LD,  32'd1);
        expect_val("c6_wpc", S_WPC, 32'h140);
        check_all();
        tick();

        // c7: 0x140 evicted 0x100 (same index)
        ex_idle();
        fetch(32'h100, op_jal, 1'b0);
        expect_val("c7_cnt",    S_CNT,  32'd2);
        expect_val("c7_100_pt", S_PT,   32'd0);
        expect_val("c7_100_nx", S_NEXT, 32'h104);
        check_all();
        fetch(32'h140, op_br, 1'b0);
        expect_val("c7_140_pt", S_PT,   32'd0);
        expect_val("c7_140_nx", S_NEXT, 32'h144);
        check_all();
        tick();

        // c8
        fetch(32'h144, op_alu, 1'b0);
        tick();

        // c9: branch fetched with pred_br=0 resolves taken
        fetch(32'h148, op_alu, 1'b0);
        ex_set(32'h140, 1'b1, 1'b0, 1'b1, 32'h180);
        expect_val("c9_mp",  S_MP,  32'd1);
        expect_val("c9_red", S_RED, 32'h180);
        expect_val("c9_ld",  S_LD,  32'd1);
        expect_val("c9_wpc", S_WPC, 32'h140);
        check_all();
        tick();

        // c10: predicted taken fetch of 0x140
        ex_idle();
        fetch(32'h140, op_br, 1'b1);
        expect_val("c10_cnt", S_CNT,  32'd3);
        expect_val("c10_pt",  S_PT,   32'd1);
        expect_val("c10_nx",  S_NEXT, 32'h180);
        check_all();
        tick();

        // c11
        fetch(32'h180, op_alu, 1'b0);
        tick();

        // c12-c14: resolution held by stall
        stall = 1'b1;
        ex_set(32'h140, 1'b1, 1'b0, 1'b0, 32'h180);
        for (int i = 0; i < 3; i++) begin
            expect_val("stall_mp",  S_MP,  32'd0);
            expect_val("stall_ld",  S_LD,  32'd0);
            expect_val("stall_red", S_RED, 32'h144);
            expect_val("stall_cnt", S_CNT, 32'd3);
            check_all();
            tick();
        end

        // c15: stall drops, single pulse
        stall = 1'b0;
        expect_val("c15_mp",  S_MP,  32'd1);
        expect_val("c15_ld",  S_LD,  32'd1);
        expect_val("c15_red", S_RED, 32'h144);
        expect_val("c15_wpc", S_WPC, 32'h140);
        check_all();
        tick();

        // c16: pulse over; not-taken left the entry in place
        ex_idle();
        fetch(32'h140, op_br, 1'b1);
        expect_val("c16_mp",  S_MP,   32'd0);
        expect_val("c16_ld",  S_LD,   32'd0);
        expect_val("c16_cnt", S_CNT,  32'd4);
        expect_val("c16_pt",  S_PT,   32'd1);
        expect_val("c16_nx",  S_NEXT, 32'h180);
        check_all();
        tick();

        // c17
        fetch(32'h180, op_alu, 1'b0);
        tick();

        // c18: JAL 0x500->0x600 (wrong target), same-cycle read sees old entry
        ex_set(32'h500, 1'b0, 1'b1, 1'b0, 32'h600);
        fetch(32'h500, op_jal, 1'b0);
        expect_val("c18_mp",  S_MP,   32'd1);
        expect_val("c18_red", S_RED,  32'h600);
        expect_val("c18_pt",  S_PT,   32'd0);
        expect_val("c18_nx",  S_NEXT, 32'h504);
        check_all();
        tick();

        // c19: aliasing
        ex_idle();
        fetch(32'h100, op_jal, 1'b0);
        expect_val("c19_cnt",   S_CNT,  32'd5);
        expect_val("alias_100", S_NEXT, 32'h104);
        check_all();
        fetch(32'h140, op_br, 1'b1);
        expect_val("alias_140", S_NEXT, 32'h144);
        check_all();
        fetch(32'h500, op_jal, 1'b0);
        expect_val("alias_500_pt", S_PT,   32'd1);
        expect_val("alias_500_nx", S_NEXT, 32'h600);
        check_all();
        tick();

        // c20
        fetch(32'h600, op_alu, 1'b0);
        tick();

        // c21: counter near saturation
        force dut.mispredict_count = 16'hFFFE;
        #1;
        release dut.mispredict_count;
        ex_set(32'h500, 1'b0, 1'b1, 1'b0, 32'h700);
        fetch(32'h604, op_alu, 1'b0);
        expect_val("c21_cnt", S_CNT, 32'hFFFE);
        expect_val("c21_mp",  S_MP,  32'd1);
        expect_val("c21_red", S_RED, 32'h700);
        check_all();
        tick();

        // c22
        ex_idle();
        fetch(32'h500, op_jal, 1'b0);
        expect_val("c22_cnt", S_CNT,  32'hFFFF);
        expect_val("c22_pt",  S_PT,   32'd1);
        expect_val("c22_nx",  S_NEXT, 32'h700);
        check_all();
        tick();

        // c23
        fetch(32'h700, op_alu, 1'b0);
        tick();

        // c24: mispredict at saturation
        ex_set(32'h500, 1'b0, 1'b1, 1'b0, 32'h800);
        fetch(32'h704, op_alu, 1'b0);
        expect_val("c24_mp",  S_MP,  32'd1);
        expect_val("c24_cnt", S_CNT, 32'hFFFF);
        check_all();
        tick();

        // c25: saturated, then asynchronous reset mid-cycle
        ex_idle();
        fetch(32'h500, op_jal, 1'b0);
        expect_val("sat_cnt", S_CNT,  32'hFFFF);
        expect_val("c25_pt",  S_PT,   32'd1);
        expect_val("c25_nx",  S_NEXT, 32'h800);
        check_all();
        rst = 1'b0;
        ex_set(32'h500, 1'b0, 1'b1, 1'b0, 32'h900);
        expect_val("arst_cnt", S_CNT,  32'd0);
        expect_val("arst_pt",  S_PT,   32'd0);
        expect_val("arst_nx",  S_NEXT, 32'h504);
        expect_val("arst_mp",  S_MP,   32'd0);
        check_all();
        ex_idle();
        rst = 1'b1;
        expect_val("post_rst_pt", S_PT,   32'd0);
        expect_val("post_rst_nx", S_NEXT, 32'h504);
        check_all();
        tick();

        // c26: lookup after reset still misses
        expect_val("c26_pt",  S_PT,   32'd0);
        expect_val("c26_nx",  S_NEXT, 32'h504);
        expect_val("c26_cnt", S_CNT,  32'd0);
        check_all();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
